// File: rtl/uart_mmio_pkg.sv
// Shared constants, FSM state types and divisor helpers for the UART MMIO block.
package uart_mmio_pkg;

  // Register offsets, selected by data_addr[3:2]
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_RXDATA  = 2'd2;
  localparam logic [1:0] OFF_DIVISOR = 2'd3;

  // STATUS bit positions
  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_TX_BUSY   = 1;
  localparam int unsigned ST_RX_VALID  = 2;
  localparam int unsigned ST_TX_OVF    = 3;
  localparam int unsigned ST_RX_OVF    = 4;
  localparam int unsigned ST_FRAME_ERR = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // A programmed divisor of 0 behaves as 1
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  // Start-bit centring delay: floor(d/2), never less than 1
  function automatic logic [15:0] half_div(input logic [15:0] d);
    logic [15:0] h;
    h = d >> 1;
    return (h == 16'd0) ? 16'd1 : h;
  endfunction

endpackage

// File: rtl/uart_mmio_sync.sv
// Synchronous FIFO; a push is refused when full, judged before any same-cycle pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Pointer and occupancy tracking
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: TX FIFO + serializer, 2-flop synchronized RX into a holding register.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wr_en,
  output logic [31:0] data_rd,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic        w_sel, w_wr;
  logic [1:0]  w_off;
  logic        w_txdata_wr, w_status_wr, w_rxdata_clr;
  logic        w_unused;

  assign w_sel        = (data_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off        = data_addr[3:2];
  assign w_wr         = w_sel && (data_wr_en != 4'd0);
  assign w_txdata_wr  = w_wr && (w_off == OFF_TXDATA) && data_wr_en[0];
  assign w_status_wr  = w_wr && (w_off == OFF_STATUS) && data_wr_en[0];
  assign w_rxdata_clr = w_wr && (w_off == OFF_RXDATA) && data_wr_en[0];
  assign w_unused     = ^{data_wr[31:16], data_addr[1:0]};

  // Registers and flags
  logic [15:0] r_div, w_div_eff;
  logic        r_tx_ovf, r_rx_ovf, r_rx_valid, r_frame_err;
  logic [7:0]  r_rx_byte;

  assign w_div_eff = eff_div(r_div);

  // TX FIFO
  logic          w_fifo_full, w_fifo_empty, w_tx_pop;
  logic [7:0]    w_fifo_rdata;
  logic [CW-1:0] w_fifo_count;
  logic          w_tx_full, w_tx_busy;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txfifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_txdata_wr),
    .i_pop   (w_tx_pop),
    .i_wdata (data_wr[7:0]),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_tx_full = (w_fifo_count == CW'(FIFO_DEPTH));

  // TX FSM state
  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic [15:0] r_tx_cnt, w_tx_cnt_nxt, r_tx_div, w_tx_div_nxt;
  logic [2:0]  r_tx_bit, w_tx_bit_nxt;
  logic [7:0]  r_tx_shift, w_tx_shift_nxt;
  logic        r_uart_tx, w_uart_tx_nxt;
  logic        w_tx_bit_end;

  assign uart_tx      = r_uart_tx;
  assign w_tx_busy    = (r_tx_state != TX_IDLE) || !w_fifo_empty;
  assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);

  // TX state register; the line itself is registered so it changes on the state edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= 16'd1;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_div   <= w_tx_div_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_uart_tx  <= w_uart_tx_nxt;
    end
  end

  // TX next state: STOP chains straight into START when more data is queued
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + 16'd1;
    w_tx_div_nxt   = r_tx_div;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_uart_tx_nxt  = r_uart_tx;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt  = '0;
        w_uart_tx_nxt = 1'b1;
        if (!w_fifo_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_div_nxt   = w_div_eff;
          w_tx_shift_nxt = w_fifo_rdata;
          w_tx_state_nxt = TX_START;
          w_uart_tx_nxt  = 1'b0;
        end
      end
      TX_START: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
          w_uart_tx_nxt  = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = TX_STOP;
            w_uart_tx_nxt  = 1'b1;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            w_tx_shift_nxt = r_tx_shift >> 1;
            w_uart_tx_nxt  = r_tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt = '0;
          if (!w_fifo_empty) begin
            w_tx_pop       = 1'b1;
            w_tx_div_nxt   = w_div_eff;
            w_tx_shift_nxt = w_fifo_rdata;
            w_tx_state_nxt = TX_START;
            w_uart_tx_nxt  = 1'b0;
          end else begin
            w_tx_state_nxt = TX_IDLE;
            w_uart_tx_nxt  = 1'b1;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // RX synchronizer plus one history flop for falling-edge detection
  logic r_rx_s1, r_rx_s2, r_rx_prev;

  // RX input synchronizer, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX FSM state
  rx_state_t   r_rx_state, w_rx_state_nxt;
  logic [15:0] r_rx_cnt, w_rx_cnt_nxt, r_rx_div, w_rx_div_nxt;
  logic [2:0]  r_rx_bit, w_rx_bit_nxt;
  logic [7:0]  r_rx_shift, w_rx_shift_nxt;
  logic        w_rx_done_ok, w_rx_done_bad;

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= 16'd1;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_div   <= w_rx_div_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // RX next state: half-bit wait centres all later samples in their bit cells
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + 16'd1;
    w_rx_div_nxt   = r_rx_div;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_done_ok   = 1'b0;
    w_rx_done_bad  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_div_nxt   = w_div_eff;
          w_rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (r_rx_cnt == half_div(r_rx_div) - 16'd1) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == r_rx_div - 16'd1) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == r_rx_div - 16'd1) begin
          w_rx_cnt_nxt   = '0;
          w_rx_done_ok   = r_rx_s2;
          w_rx_done_bad  = !r_rx_s2;
          w_rx_state_nxt = RX_IDLE;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Programmable registers and sticky flags; a same-cycle set beats any clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= CLKS_PER_BIT;
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_byte   <= '0;
    end else begin
      if (w_wr && (w_off == OFF_DIVISOR)) begin
        if (data_wr_en[0]) r_div[7:0]  <= data_wr[7:0];
        if (data_wr_en[1]) r_div[15:8] <= data_wr[15:8];
      end
      r_tx_ovf    <= (w_txdata_wr && w_fifo_full) ||
                     (r_tx_ovf && !(w_status_wr && data_wr[ST_TX_OVF]));
      r_rx_ovf    <= (w_rx_done_ok && r_rx_valid && !w_rxdata_clr) ||
                     (r_rx_ovf && !(w_status_wr && data_wr[ST_RX_OVF]));
      r_frame_err <= w_rx_done_bad ||
                     (r_frame_err && !(w_status_wr && data_wr[ST_FRAME_ERR]));
      r_rx_valid  <= w_rx_done_ok || (r_rx_valid && !w_rxdata_clr);
      if (w_rx_done_ok) r_rx_byte <= r_rx_shift;
    end
  end

  // Combinational read mux, zero outside the window
  always_comb begin
    data_rd = '0;
    if (w_sel) begin
      case (w_off)
        OFF_STATUS: begin
          data_rd[ST_TX_FULL]   = w_tx_full;
          data_rd[ST_TX_BUSY]   = w_tx_busy;
          data_rd[ST_RX_VALID]  = r_rx_valid;
          data_rd[ST_TX_OVF]    = r_tx_ovf;
          data_rd[ST_RX_OVF]    = r_rx_ovf;
          data_rd[ST_FRAME_ERR] = r_frame_err;
        end
        OFF_RXDATA:  data_rd[7:0]  = r_rx_byte;
        OFF_DIVISOR: data_rd[15:0] = r_div;
        default:     data_rd       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: serial streams and RX flags against a behavioural model.
module tb_uart_mmio;
  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_RX  = 32'h1000_0008;
  localparam logic [31:0] A_DIV = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wr = '0;
  logic [3:0]  data_wr_en = '0;
  logic [31:0] data_rd;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int errors = 0;
  int checks = 0;

  bit   rec = 1'b0;
  logic q[$];
  logic exp_q[$];

  bit         m_valid = 0, m_ovf = 0, m_ferr = 0;
  logic [7:0] m_byte = '0;

  always #5 clk = ~clk;

  uart_mmio #(.BASE_ADDR(32'h1000_0000), .FIFO_DEPTH(4), .CLKS_PER_BIT(16'd868)) dut (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_wr(data_wr),
    .data_wr_en(data_wr_en), .data_rd(data_rd), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always @(negedge clk) if (rec) q.push_back(uart_tx);

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
    data_addr = a; data_wr = d; data_wr_en = en;
    cyc(1);
    data_wr_en = '0; data_addr = '0; data_wr = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    data_addr = a; #1; v = data_rd; data_addr = '0;
  endtask

  // Ideal line waveform of one frame, one entry per clock
  task automatic add_frame(input logic [7:0] b, input int unsigned eff);
    repeat (eff) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (eff) exp_q.push_back(b[i]);
    repeat (eff) exp_q.push_back(1'b1);
  endtask

  function automatic int first_diff();
    if (q.size() < exp_q.size()) return -2;
    foreach (exp_q[i]) if (q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic wait_stream();
    for (int t = 0; t < 20000 && q.size() < exp_q.size(); t++) cyc(1);
    rec = 1'b0;
  endtask

  function automatic logic [31:0] m_status();
    return {26'h0, m_ferr, m_ovf, 1'b0, m_valid, 2'b00};
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop, input int unsigned eff);
    uart_rx = 1'b0; cyc(eff);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; cyc(eff); end
    uart_rx = stop; cyc(eff);
    uart_rx = 1'b1; cyc(2 * eff + 6);
    if (stop) begin
      if (m_valid) m_ovf = 1;
      m_byte = b; m_valid = 1;
    end else m_ferr = 1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0; cyc(3); rst_n = 1'b1; cyc(1);
    rd(A_ST, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want %h", v, 32'h0); end
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
    rd(A_DIV, v); checks++;
    if (v !== 32'd868) begin errors++; $display("FAIL reset_divisor: got %0d want 868", v); end
    rd(A_RX, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_rxdata: got %h want 0", v); end
  endtask

  task automatic test_regs();
    logic [31:0] v;
    wr(A_DIV, 32'hFFFF_FFFF, 4'hF); rd(A_DIV, v); checks++;
    if (v !== 32'h0000_FFFF) begin errors++; $display("FAIL div_upper_zero: got %h want %h", v, 32'hFFFF); end
    wr(A_DIV, 32'h0000_1234, 4'b0001); rd(A_DIV, v); checks++;
    if (v !== 32'h0000_FF34) begin errors++; $display("FAIL div_lane0: got %h want %h", v, 32'hFF34); end
    wr(32'h2000_000C, 32'h5, 4'hF); rd(32'h2000_000C, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL outside_window_read: got %h want 0", v); end
    rd(A_DIV, v); checks++;
    if (v !== 32'h0000_FF34) begin errors++; $display("FAIL outside_window_write: got %h want %h", v, 32'hFF34); end
    rd(A_TX, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h want 0", v); end
  endtask

  task automatic test_tx_single();
    logic [31:0] v;
    int d;
    wr(A_DIV, 32'd4, 4'b0011);
    q.delete(); exp_q.delete();
    exp_q.push_back(1'b1); add_frame(8'hA5, 4); repeat (3) exp_q.push_back(1'b1);
    wr(A_TX, 32'hA5, 4'b0001); rec = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      cyc(1);
      if (k == 40) begin
        rd(A_ST, v); checks++;
        if (v[1] !== 1'b1) begin errors++; $display("FAIL tx_busy_before_end: got %b want 1", v[1]); end
      end
      if (k == 41) begin
        rd(A_ST, v); checks++;
        if (v[1] !== 1'b0) begin errors++; $display("FAIL tx_busy_after_end: got %b want 0", v[1]); end
      end
    end
    wait_stream();
    d = first_diff(); checks++;
    if (d != -1) begin errors++; $display("FAIL tx_single_stream: got diff_at=%0d want -1", d); end
  endtask

  task automatic test_tx_fifo();
    logic [31:0] v;
    int d;
    wr(A_DIV, 32'd16, 4'b0011);
    q.delete(); exp_q.delete(); exp_q.push_back(1'b1);
    for (int b = 1; b <= 5; b++) add_frame(8'(b), 16);
    repeat (3) exp_q.push_back(1'b1);
    wr(A_TX, 32'd1, 4'b0001); rec = 1'b1;
    for (int b = 2; b <= 6; b++) wr(A_TX, 32'(b), 4'b0001);
    rd(A_ST, v); checks++;
    if (v !== 32'h0B) begin errors++; $display("FAIL fifo_full_ovf: got %h want %h", v, 32'h0B); end
    wr(A_ST, 32'h08, 4'b0001); rd(A_ST, v); checks++;
    if (v !== 32'h03) begin errors++; $display("FAIL tx_ovf_clear: got %h want %h", v, 32'h03); end
    wait_stream();
    d = first_diff(); checks++;
    if (d != -1) begin errors++; $display("FAIL fifo_stream: got diff_at=%0d want -1", d); end
  endtask

  task automatic test_back_to_back();
    int d;
    wr(A_DIV, 32'd4, 4'b0011);
    q.delete(); exp_q.delete(); exp_q.push_back(1'b1);
    add_frame(8'h5A, 4); add_frame(8'hC3, 6); repeat (3) exp_q.push_back(1'b1);
    wr(A_TX, 32'h5A, 4'b0001); rec = 1'b1;
    wr(A_TX, 32'hC3, 4'b0001);
    cyc(8);
    wr(A_DIV, 32'd6, 4'b0011);
    wait_stream();
    d = first_diff(); checks++;
    if (d != -1) begin errors++; $display("FAIL div_midframe_stream: got diff_at=%0d want -1", d); end
  endtask

  task automatic test_tx_random();
    logic [31:0] v;
    logic [7:0]  bs [7];
    int unsigned div, n, eff;
    int d;
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(0, 5);
      n   = $urandom_range(1, 7);
      eff = (div == 0) ? 1 : div;
      for (int i = 0; i < 7; i++) bs[i] = 8'($urandom);
      wr(A_DIV, div, 4'b0011);
      rd(A_DIV, v); checks++;
      if (v !== div) begin errors++; $display("FAIL rand_div_readback: got %0d want %0d", v, div); end
      q.delete(); exp_q.delete(); exp_q.push_back(1'b1);
      for (int i = 0; i < n && i < 5; i++) add_frame(bs[i], eff);
      repeat (3) exp_q.push_back(1'b1);
      for (int i = 0; i < n; i++) begin
        wr(A_TX, {24'h0, bs[i]}, 4'b0001);
        if (i == 0) rec = 1'b1;
      end
      rd(A_ST, v); checks++;
      if (v[3] !== (n > 5)) begin errors++; $display("FAIL rand_tx_ovf: got %b want %b", v[3], n > 5); end
      wr(A_ST, 32'h08, 4'b0001);
      wait_stream();
      d = first_diff(); checks++;
      if (d != -1) begin errors++; $display("FAIL rand_tx_stream: got diff_at=%0d want -1 (div %0d n %0d)", d, div, n); end
      rd(A_ST, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL rand_tx_idle_status: got %h want 0", v); end
    end
  endtask

  task automatic test_rx_basic();
    logic [31:0] v;
    wr(A_DIV, 32'd8, 4'b0011);
    send_rx(8'h3C, 1'b1, 8);
    rd(A_ST, v); checks++;
    if (v !== m_status()) begin errors++; $display("FAIL rx_first_status: got %h want %h", v, m_status()); end
    rd(A_RX, v); checks++;
    if (v !== {24'h0, m_byte}) begin errors++; $display("FAIL rx_first_data: got %h want %h", v, m_byte); end
    send_rx(8'h55, 1'b1, 8);
    rd(A_ST, v); checks++;
    if (v !== m_status()) begin errors++; $display("FAIL rx_ovf_status: got %h want %h", v, m_status()); end
    rd(A_RX, v); checks++;
    if (v !== {24'h0, m_byte}) begin errors++; $display("FAIL rx_ovf_data: got %h want %h", v, m_byte); end
    wr(A_ST, 32'h10, 4'b0001); m_ovf = 0;
    wr(A_RX, 32'h0, 4'b0001);  m_valid = 0;
    rd(A_ST, v); checks++;
    if (v !== m_status()) begin errors++; $display("FAIL rx_clear_status: got %h want %h", v, m_status()); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] v;
    wr(A_DIV, 32'd8, 4'b0011);
    uart_rx = 1'b0; cyc(2); uart_rx = 1'b1; cyc(24);
    rd(A_ST, v); checks++;
    if (v !== m_status()) begin errors++; $display("FAIL rx_glitch_status: got %h want %h", v, m_status()); end
    send_rx(8'($urandom), 1'b0, 8);
    rd(A_ST, v); checks++;
    if (v !== m_status()) begin errors++; $display("FAIL rx_frame_err_status: got %h want %h", v, m_status()); end
    rd(A_RX, v); checks++;
    if (v !== {24'h0, m_byte}) begin errors++; $display("FAIL rx_frame_err_data: got %h want %h", v, m_byte); end
    wr(A_ST, 32'h20, 4'b0001); m_ferr = 0;
  endtask

  task automatic test_rx_random();
    logic [31:0] v;
    logic [5:0]  mask;
    int unsigned div;
    logic [7:0]  b;
    logic        stop;
    for (int it = 0; it < 6; it++) begin
      div  = $urandom_range(4, 12);
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      wr(A_DIV, div, 4'b0011);
      send_rx(b, stop, div);
      rd(A_ST, v); checks++;
      if (v !== m_status()) begin errors++; $display("FAIL rand_rx_status: got %h want %h", v, m_status()); end
      rd(A_RX, v); checks++;
      if (v !== {24'h0, m_byte}) begin errors++; $display("FAIL rand_rx_data: got %h want %h", v, m_byte); end
      case ($urandom_range(0, 2))
        1: begin wr(A_RX, 32'h0, 4'b0001); m_valid = 0; end
        2: begin
          mask = 6'($urandom);
          wr(A_ST, {26'h0, mask}, 4'b0001);
          if (mask[5]) m_ferr = 0;
          if (mask[4]) m_ovf = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    int ones;
    wr(A_DIV, 32'd16, 4'b0011);
    wr(A_TX, 32'hFF, 4'b0001);
    wr(A_TX, 32'h11, 4'b0001);
    wr(A_TX, 32'h22, 4'b0001);
    checks++;
    if (uart_tx !== 1'b0) begin errors++; $display("FAIL pre_reset_start_bit: got %b want 0", uart_tx); end
    #2 rst_n = 1'b0;
    #1 checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b want 1", uart_tx); end
    cyc(2); rst_n = 1'b1; cyc(1);
    rd(A_ST, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL post_reset_status: got %h want 0", v); end
    rd(A_DIV, v); checks++;
    if (v !== 32'd868) begin errors++; $display("FAIL post_reset_divisor: got %0d want 868", v); end
    q.delete(); rec = 1'b1; cyc(200); rec = 1'b0;
    ones = 0;
    foreach (q[i]) if (q[i] === 1'b1) ones++;
    checks++;
    if (ones != 200) begin errors++; $display("FAIL post_reset_line_idle: got %0d high cycles want 200", ones); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_single();
    test_tx_fifo();
    test_back_to_back();
    test_tx_random();
    test_rx_basic();
    test_rx_errors();
    test_rx_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
